// File: rtl/assoc_cache_pkg.sv
// Shared definitions for assoc_cache: FSM state encoding and the LRU age-width helper.
package assoc_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        FILL,
        WTHRU,
        RESP
    } state_t;

    // Width of a per-line age, also wide enough to index any line.
    function automatic int age_w(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/assoc_cache_lru.sv
// LRU bookkeeping for assoc_cache: per-line ages kept as a permutation, plus victim selection.
module assoc_cache_lru
    import assoc_cache_pkg::*;
#(
    parameter  int LINES = 4,
    localparam int IW    = age_w(LINES)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             touch,
    input  logic [IW-1:0]    touch_idx,
    input  logic [LINES-1:0] valid,
    output logic [IW-1:0]    victim
);

    logic [IW-1:0] age [LINES];

    // NOTE: sequential state uses non-blocking assignments so every line sees the pre-edge ages.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < LINES; i++) age[i] <= IW'(LINES - 1 - i);
        end else if (touch) begin
            for (int i = 0; i < LINES; i++) begin
                if (IW'(i) == touch_idx)
                    age[i] <= '0;
                else if (age[i] < age[touch_idx])
                    age[i] <= age[i] + IW'(1);
            end
        end
    end

    // Invalid lines win over the oldest; the descending scan leaves the lowest invalid index.
    always_comb begin
        victim = '0;
        for (int i = 0; i < LINES; i++)
            if (age[i] == IW'(LINES - 1)) victim = IW'(i);
        for (int i = LINES - 1; i >= 0; i--)
            if (!valid[i]) victim = IW'(i);
    end

endmodule

// File: rtl/assoc_cache.sv
// Fully associative cache of one-word lines with LRU replacement and a req/ack backing memory.
// Define ASSOC_CACHE_WRITE_BACK_EN for write-back/write-allocate; default is write-through/no-allocate.
module assoc_cache
    import assoc_cache_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LINES  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enab,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    output logic              done,
    output logic              ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int IW = age_w(LINES);

    state_t            state_q, state_d;
    logic [LINES-1:0]  valid;
    logic [ADDR_W-1:0] tag  [LINES];
    logic [DATA_W-1:0] data [LINES];
`ifdef ASSOC_CACHE_WRITE_BACK_EN
    logic [LINES-1:0]  dirty;
    logic              line_dirty;
`endif

    logic              l_rw, l_hit;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_data;
    logic [IW-1:0]     l_idx;

    logic              hit_any, touch, line_we, resp_set, resp_hit;
    logic [IW-1:0]     hit_idx, victim, touch_idx, line_idx;
    logic [ADDR_W-1:0] line_tag;
    logic [DATA_W-1:0] line_wdata, resp_data;

    assoc_cache_lru #(.LINES(LINES)) u_lru (
        .clk       (clk),
        .clr       (clr),
        .touch     (touch),
        .touch_idx (touch_idx),
        .valid     (valid),
        .victim    (victim)
    );

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < LINES; i++) begin
            if (valid[i] && tag[i] == addr) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ready      = (state_q == IDLE);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        touch      = 1'b0;
        touch_idx  = hit_idx;
        line_we    = 1'b0;
        line_idx   = hit_idx;
        line_tag   = addr;
        line_wdata = data_in;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
        line_dirty = 1'b0;
`endif
        resp_set   = 1'b0;
        resp_hit   = 1'b0;
        resp_data  = '0;
        unique case (state_q)
            IDLE: if (enab) begin
                if (hit_any) begin
                    touch = 1'b1;
                    if (!rw) begin
                        resp_set  = 1'b1;
                        resp_hit  = 1'b1;
                        resp_data = data[hit_idx];
                    end else begin
                        line_we = 1'b1;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
                        line_dirty = 1'b1;
                        resp_set   = 1'b1;
                        resp_hit   = 1'b1;
                        resp_data  = data_in;
`else
                        state_d = WTHRU;
`endif
                    end
                end else begin
`ifdef ASSOC_CACHE_WRITE_BACK_EN
                    if (valid[victim] && dirty[victim]) begin
                        state_d = EVICT;
                    end else if (rw) begin
                        state_d    = RESP;
                        touch      = 1'b1;
                        touch_idx  = victim;
                        line_we    = 1'b1;
                        line_idx   = victim;
                        line_dirty = 1'b1;
                        resp_set   = 1'b1;
                        resp_data  = data_in;
                    end else begin
                        state_d = FILL;
                    end
`else
                    state_d = rw ? WTHRU : FILL;
`endif
                end
            end
            EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = tag[l_idx];
                mem_wdata = data[l_idx];
                if (mem_ack) begin
                    if (l_rw) begin
                        state_d    = RESP;
                        touch      = 1'b1;
                        touch_idx  = l_idx;
                        line_we    = 1'b1;
                        line_idx   = l_idx;
                        line_tag   = l_addr;
                        line_wdata = l_data;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
                        line_dirty = 1'b1;
`endif
                        resp_set   = 1'b1;
                        resp_data  = l_data;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = l_addr;
                if (mem_ack) begin
                    state_d    = RESP;
                    touch      = 1'b1;
                    touch_idx  = l_idx;
                    line_we    = 1'b1;
                    line_idx   = l_idx;
                    line_tag   = l_addr;
                    line_wdata = mem_rdata;
                    resp_set   = 1'b1;
                    resp_data  = mem_rdata;
                end
            end
            WTHRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = l_addr;
                mem_wdata = l_data;
                if (mem_ack) begin
                    state_d   = RESP;
                    resp_set  = 1'b1;
                    resp_hit  = l_hit;
                    resp_data = l_data;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid    <= '0;
            data_out <= '0;
            hit      <= 1'b0;
            done     <= 1'b0;
            l_rw     <= 1'b0;
            l_hit    <= 1'b0;
            l_addr   <= '0;
            l_data   <= '0;
            l_idx    <= '0;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
            dirty    <= '0;
`endif
        end else begin
            done <= resp_set;
            hit  <= resp_hit;
            if (resp_set) data_out <= resp_data;
            if (line_we) begin
                valid[line_idx] <= 1'b1;
`ifdef ASSOC_CACHE_WRITE_BACK_EN
                dirty[line_idx] <= line_dirty;
`endif
            end
            if (state_q == IDLE && enab) begin
                l_rw   <= rw;
                l_hit  <= hit_any;
                l_addr <= addr;
                l_data <= data_in;
                l_idx  <= hit_any ? hit_idx : victim;
            end
        end
    end

    // NOTE: tag/data storage is not reset; valid bits alone decide whether a line's contents count.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag[line_idx]  <= line_tag;
            data[line_idx] <= line_wdata;
        end
    end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 8, data word width in bits.
REQ-003 Parameter LINES, default 4, number of one-word lines; power of two, >= 2.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 enab  in  1  request strobe; sampled only when ready=1.
REQ-007 rw  in  1  1=write, 0=read.
REQ-008 addr  in  ADDR_W  request address; full address is the line tag.
REQ-009 data_in  in  DATA_W  write data.
REQ-010 data_out  out  DATA_W  read result; valid when done=1.
REQ-011 hit  out  1  one-cycle pulse with done when the request hit.
REQ-012 done  out  1  one-cycle pulse on request completion.
REQ-013 ready  out  1  1 only in IDLE.
REQ-014 mem_req, mem_we  out  1 each  backing-memory request and direction.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W; mem_ack  in  1.

Function
REQ-016 FSM states SHALL be IDLE, EVICT, FILL, WTHRU, RESP.
REQ-017 IDLE, enab=1: lookup compares addr against all valid tags in the same cycle.
REQ-018 Read hit: data_out, hit=1, done=1 registered at that edge; FSM stays IDLE (latency 1).
REQ-019 Read miss: victim selected; dirty victim -> EVICT, else -> FILL.
REQ-020 Victim = lowest-index invalid line; if none, line with age LINES-1.
REQ-021 LRU: per-line age of log2(LINES) bits; accessed line -> 0; lines younger than its old age increment; ages stay a permutation.
REQ-022 EVICT: mem_req=1, mem_we=1, mem_addr=victim tag, mem_wdata=victim data; on mem_ack -> FILL (read) or install (write).
REQ-023 FILL: mem_req=1, mem_we=0, mem_addr=latched addr; on mem_ack line <= mem_rdata, valid=1, dirty=0, tag set -> RESP.
REQ-024 RESP: data_out=line data, done=1, hit=0 for one cycle -> IDLE.
REQ-025 mem_req/mem_we/mem_addr/mem_wdata SHALL stay stable until the cycle mem_ack=1; mem_req drops the edge after ack.
REQ-026 mem_ack while mem_req=0 SHALL be ignored.
REQ-027 Request inputs latched at acceptance; changes while ready=0 ignored.
REQ-028 Every hit or install updates LRU; lookups that miss do not until install.

Reset
REQ-029 clr=1: state IDLE, all valid/dirty 0, age[i]=LINES-1-i, data_out=0, hit=done=mem_req=mem_we=0, mem_addr=mem_wdata=0.
REQ-030 clr mid-transaction drops mem_req immediately; dirty data is discarded.

Configuration
REQ-031 Macro ASSOC_CACHE_WRITE_BACK_EN defined: write-back, write-allocate; write hit updates line, dirty=1, hit=done=1, stays IDLE; write miss evicts if dirty, installs data_in with dirty=1 -> RESP.
REQ-032 Macro undefined: write-through, no-allocate, no dirty bits, EVICT unreachable; write hit updates line and goes WTHRU; write miss goes WTHRU without allocation; WTHRU issues mem write of latched addr/data until ack -> RESP (hit=1 if it was a hit).

Structure
REQ-033 Package assoc_cache_pkg SHALL hold the FSM state enum and a clog2-based age-width constant function.
REQ-034 Sub-module assoc_cache_lru SHALL hold age registers, update logic and victim select.

Verification (LINES=4, ADDR_W=DATA_W=8)
REQ-035 Reset -> ready=1, hit=done=mem_req=0, data_out=0x00.
REQ-036 Read 0x10 cold, mem_ack with 0xA5 after 2 cycles -> done=1, hit=0, data_out=0xA5; reread 0x10 -> hit=done=1 next edge, no mem_req.
REQ-037 Read 0x01..0x04, reread 0x01, read 0x05 -> FILL replaces 0x02; reread 0x01 hits.
REQ-038 WB: write 0x20=0x3C, fill 4 other addresses -> mem write addr 0x20 data 0x3C precedes fill read.
REQ-039 WT: write 0x30=0x77 -> mem_req=1, mem_we=1, mem_addr=0x30, mem_wdata=0x77; read 0x30 afterwards misses.
REQ-040 clr pulse during FILL with mem_req=1 -> mem_req=0 before next edge, ready=1; read 0x10 then misses.
